// File: rtl/uart_word_sequencer_pkg.sv
// Shared definitions for the UART word sequencer: FSM state codes, status-byte
// layout and the bytes-per-word derivation.
package uart_word_sequencer_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RX_COLLECT = 3'd1;
    localparam logic [2:0] ST_LAUNCH     = 3'd2;
    localparam logic [2:0] ST_WAIT_DP    = 3'd3;
    localparam logic [2:0] ST_TX_SEND    = 3'd4;

    // Status byte returned after the result bytes: {6'b0, timeout, err}.
    localparam int STATUS_ERR_BIT     = 0;
    localparam int STATUS_TIMEOUT_BIT = 1;

    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_word_sequencer_timeout.sv
// Saturating timeout counter: counts enabled cycles since the last clear and
// raises hit once LIMIT is reached; it holds there instead of wrapping.
module sat_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int            W   = $clog2(LIMIT + 1);
    localparam logic [W-1:0]  MAX = W'(LIMIT);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

    assign hit = (count == MAX);

endmodule

// File: rtl/uart_word_sequencer.sv
// Sequences UART bytes into a K-bit word for the ECC datapath and streams the
// decoded word plus a status byte back to the UART transmitter.
module uart_word_sequencer
    import uart_word_sequencer_pkg::*;
#(
    parameter int K       = 17,
    parameter int GAP_CYC = 200000,
    parameter int DP_CYC  = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic         tx_ready,
    output logic         tx_valid,
    output logic [7:0]   tx_data,
    output logic         dp_start,
    output logic [K-1:0] dp_data,
    input  logic         dp_done,
    input  logic [K-1:0] dp_result,
    input  logic         dp_err,
    output logic         busy
);

    localparam int NB    = bytes_per_word(K);
    localparam int PW    = NB * 8;
    localparam int IDX_W = $clog2(NB + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NB - 1);
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NB);

    logic [2:0]       state;
    logic [IDX_W-1:0] idx;        // RX byte index while collecting, TX byte index while sending
    logic [K-1:0]     result;
    logic             err_q;
    logic             timeout_q;
    logic             gap_hit;
    logic             dp_hit;
    logic [PW-1:0]    word_pad;
    logic [PW-1:0]    result_pad;
    logic [K-1:0]     word_next;
    logic [7:0]       status_byte;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        word_pad = (state == ST_IDLE) ? '0 : PW'(dp_data);
        word_pad[((state == ST_IDLE) ? 0 : int'(idx)) * 8 +: 8] = rx_data;
        word_next  = word_pad[K-1:0];
        result_pad = PW'(result);
        status_byte = '0;
        status_byte[STATUS_ERR_BIT]     = err_q;
        status_byte[STATUS_TIMEOUT_BIT] = timeout_q;
    end

    // An arriving byte restarts the gap window; both counters clear whenever
    // their state is not active, so LAUNCH starts the DP window at zero.
    sat_timeout_counter #(.LIMIT(GAP_CYC)) u_gap_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  ((state != ST_RX_COLLECT) || rx_valid),
        .enable (state == ST_RX_COLLECT),
        .hit    (gap_hit)
    );

    sat_timeout_counter #(.LIMIT(DP_CYC)) u_dp_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ST_WAIT_DP),
        .enable (state == ST_WAIT_DP),
        .hit    (dp_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            dp_data   <= '0;
            dp_start  <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            result    <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            dp_start <= 1'b0;
            tx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        dp_data <= word_next;
                        idx     <= (NB == 1) ? '0 : IDX_W'(1);
                        state   <= (NB == 1) ? ST_LAUNCH : ST_RX_COLLECT;
                    end
                end
                ST_RX_COLLECT: begin
                    // A byte landing on the gap-expiry cycle still counts.
                    if (rx_valid) begin
                        dp_data <= word_next;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ST_LAUNCH;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (gap_hit) begin
                        idx   <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    dp_start <= 1'b1;
                    state    <= ST_WAIT_DP;
                end
                ST_WAIT_DP: begin
                    idx <= '0;
                    if (dp_done) begin
                        result    <= dp_result;
                        err_q     <= dp_err;
                        timeout_q <= 1'b0;
                        state     <= ST_TX_SEND;
                    end else if (dp_hit) begin
                        result    <= '0;
                        err_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        state     <= ST_TX_SEND;
                    end
                end
                ST_TX_SEND: begin
                    // Skipping the cycle after each pulse gives tx_ready time to drop.
                    if (tx_ready && !tx_valid) begin
                        tx_valid <= 1'b1;
                        if (idx == STATUS_IDX) begin
                            tx_data <= status_byte;
                            idx     <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            tx_data <= result_pad[int'(idx) * 8 +: 8];
                            idx     <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_word_sequencer.sv
// Scoreboard bench for uart_word_sequencer with a small datapath model and
// shortened gap/datapath timeouts.
module tb_uart_word_sequencer;

    localparam int K       = 17;
    localparam int GAP_CYC = 300;
    localparam int DP_CYC  = 200;
    localparam int DP_LAT  = 10;

    // Datapath model modes
    localparam int DP_ZERO      = 0;
    localparam int DP_ECHO_ERR  = 1;
    localparam int DP_ECHO_OK   = 2;
    localparam int DP_NEVER     = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         tx_ready;
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic         dp_start;
    logic [K-1:0] dp_data;
    logic         dp_done   = 1'b0;
    logic [K-1:0] dp_result = '0;
    logic         dp_err    = 1'b0;
    logic         busy;

    uart_word_sequencer #(.K(K), .GAP_CYC(GAP_CYC), .DP_CYC(DP_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .dp_start  (dp_start),
        .dp_data   (dp_data),
        .dp_done   (dp_done),
        .dp_result (dp_result),
        .dp_err    (dp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [7:0]   exp_tx[$];
    logic [K-1:0] exp_dp[$];
    logic [7:0]   e_tx;
    logic [K-1:0] e_dp;
    logic [K-1:0] cap_word = '0;
    int           dp_mode = DP_ZERO;
    int           dp_cnt = 0;
    int           tx_seen = 0;
    logic         prev_valid = 1'b0;
    logic         last_ready = 1'b1;

    // Output monitor: compares DUT traffic against the scoreboard queues.
    always @(negedge clk) begin
        if (dp_start) begin
            checks++;
            if (exp_dp.size() == 0) begin
                $display("FAIL unexpected_dp_start dp_data=%h", dp_data);
            end else begin
                e_dp = exp_dp.pop_front();
                if (dp_data !== e_dp) $display("FAIL dp_data got=%h want=%h", dp_data, e_dp);
                else passes++;
            end
            cap_word = dp_data;
            if (dp_mode != DP_NEVER) dp_cnt = DP_LAT;
        end
        if (dp_done) begin
            checks++;
            if (dp_data !== cap_word) $display("FAIL dp_data_hold got=%h want=%h", dp_data, cap_word);
            else passes++;
        end
        if (tx_valid) begin
            tx_seen++;
            checks++;
            if (exp_tx.size() == 0) begin
                $display("FAIL unexpected_tx tx_data=%h", tx_data);
            end else begin
                e_tx = exp_tx.pop_front();
                if (tx_data !== e_tx) $display("FAIL tx_data got=%h want=%h", tx_data, e_tx);
                else passes++;
            end
            checks++;
            if (prev_valid || !last_ready)
                $display("FAIL tx_handshake prev_valid=%b ready=%b want prev_valid=0 ready=1", prev_valid, last_ready);
            else passes++;
        end
        prev_valid = tx_valid;
        last_ready = tx_ready;
    end

    // Datapath model: responds DP_LAT cycles after dp_start unless disabled.
    always @(posedge clk) begin
        #1;
        dp_done = 1'b0;
        if (dp_cnt > 0) begin
            dp_cnt--;
            if (dp_cnt == 0) begin
                dp_done   = 1'b1;
                dp_result = (dp_mode == DP_ZERO) ? '0 : cap_word;
                dp_err    = (dp_mode == DP_ECHO_ERR);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input int gap);
        send_byte(b0);
        if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
        send_byte(b1);
        if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
        send_byte(b2);
    endtask

    task automatic push_dp(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [23:0] w;
        w = {b2, b1, b0};
        exp_dp.push_back(w[K-1:0]);
    endtask

    task automatic push_tx(input logic [K-1:0] word, input logic timeout, input logic err);
        logic [23:0] w;
        w = 24'(word);
        exp_tx.push_back(w[7:0]);
        exp_tx.push_back(w[15:8]);
        exp_tx.push_back(w[23:16]);
        exp_tx.push_back({6'b0, timeout, err});
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((exp_tx.size() != 0 || busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= budget) $display("FAIL %s_complete pending_tx=%0d busy=%b want 0/0", name, exp_tx.size(), busy);
        else passes++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_data, dp_start, dp_data, busy} !== '0)
            $display("FAIL reset_outputs got tv=%b td=%h ds=%b dd=%h busy=%b want all 0",
                     tx_valid, tx_data, dp_start, dp_data, busy);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle busy=%b want 0", busy);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_word();
        dp_mode = DP_ZERO;
        push_dp(8'h00, 8'h00, 8'h00);
        push_tx('0, 1'b0, 1'b0);
        send_frame(8'h00, 8'h00, 8'h00, 2);
        wait_idle(500, "zero_word");
    endtask

    task automatic test_echo_err();
        dp_mode = DP_ECHO_ERR;
        push_dp(8'hA5, 8'h3C, 8'hFF);
        push_tx(17'h13CA5, 1'b0, 1'b1);
        send_frame(8'hA5, 8'h3C, 8'hFF, 0);
        @(negedge clk);
        checks++;
        if (dp_start !== 1'b0) $display("FAIL launch_latency_early dp_start=%b want 0", dp_start);
        else passes++;
        @(negedge clk);
        checks++;
        if (dp_start !== 1'b1) $display("FAIL launch_latency dp_start=%b want 1", dp_start);
        else passes++;
        @(posedge clk); #1;
        wait_idle(500, "echo_err");
    endtask

    task automatic test_gap();
        dp_mode = DP_ECHO_OK;
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (GAP_CYC - 5) @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) $display("FAIL gap_early busy=%b want 1", busy);
        else passes++;
        repeat (10) @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL gap_drop busy=%b want 0", busy);
        else passes++;
        // Bytes arriving exactly on the gap-expiry cycle must be kept.
        push_dp(8'h5A, 8'hC3, 8'h01);
        push_tx(17'h1C35A, 1'b0, 1'b0);
        send_frame(8'h5A, 8'hC3, 8'h01, GAP_CYC);
        wait_idle(500, "gap_boundary");
    endtask

    task automatic test_dp_timeout();
        int s;
        dp_mode = DP_NEVER;
        push_dp(8'h11, 8'h22, 8'h33);
        push_tx('0, 1'b1, 1'b0);
        s = tx_seen;
        send_frame(8'h11, 8'h22, 8'h33, 1);
        repeat (DP_CYC - 10) @(posedge clk); #1;
        checks++;
        if (tx_seen != s || busy !== 1'b1)
            $display("FAIL dp_timeout_early tx_seen=%0d busy=%b want %0d/1", tx_seen, busy, s);
        else passes++;
        wait_idle(200, "dp_timeout");
    endtask

    task automatic test_back_pressure();
        int s;
        int n;
        dp_mode = DP_ECHO_OK;
        push_dp(8'h01, 8'h02, 8'h03);
        push_tx(17'h10201, 1'b0, 1'b0);
        s = tx_seen;
        send_frame(8'h01, 8'h02, 8'h03, 0);
        n = 0;
        while (tx_seen == s && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 200) $display("FAIL backpressure_first_byte tx_seen=%0d want >%0d", tx_seen, s);
        else passes++;
        tx_ready = 1'b0;
        s = tx_seen;
        repeat (50) @(posedge clk); #1;
        checks++;
        if (tx_seen != s) $display("FAIL backpressure_hold tx_seen=%0d want %0d", tx_seen, s);
        else passes++;
        tx_ready = 1'b1;
        wait_idle(200, "backpressure");
    endtask

    task automatic test_reset_mid();
        int s;
        dp_mode = DP_NEVER;
        push_dp(8'h77, 8'h66, 8'h55);
        send_frame(8'h77, 8'h66, 8'h55, 0);
        repeat (20) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || dp_start !== 1'b0)
            $display("FAIL reset_mid busy=%b tv=%b ds=%b want 0/0/0", busy, tx_valid, dp_start);
        else passes++;
        @(posedge clk); #1;
        s = tx_seen;
        repeat (DP_CYC + 20) @(posedge clk); #1;
        checks++;
        if (tx_seen != s) $display("FAIL reset_mid_no_tx tx_seen=%0d want %0d", tx_seen, s);
        else passes++;
        dp_mode = DP_ECHO_OK;
        push_dp(8'hF0, 8'h0F, 8'h00);
        push_tx(17'h00FF0, 1'b0, 1'b0);
        send_frame(8'hF0, 8'h0F, 8'h00, 3);
        wait_idle(500, "reset_mid_recover");
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        test_reset();
        test_zero_word();
        test_echo_err();
        test_gap();
        test_dp_timeout();
        test_back_pressure();
        test_reset_mid();
        repeat (5) @(posedge clk); #1;
        checks++;
        if (exp_dp.size() != 0 || exp_tx.size() != 0)
            $display("FAIL scoreboard_drain dp=%0d tx=%0d want 0/0", exp_dp.size(), exp_tx.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_word_sequencer.md
Name: uart_word_sequencer

Overview:
- Controller between the UART byte receiver/transmitter and the PEECC encode/channel/decode datapath.
- Assembles a k-bit data word from UART bytes, starts the datapath and waits for its done pulse.
- Returns the decoded word plus one status byte over the UART TX byte interface.
- Sits inside the top module, directly under the UART RX/TX instances and beside the datapath.

Parameters:
- k, 17, data word width in bits.
- NB, (k+7)/8, bytes per word; derived, not overridable.
- GAP_CYC, 200000, max clk cycles between RX bytes of one frame before the partial frame is dropped.
- DP_CYC, 4096, max clk cycles from dp_start to dp_done before a datapath timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_ready  in  1  UART TX is idle and can accept a byte.
- tx_valid  out  1  one-cycle pulse: load tx_data into the UART TX.
- tx_data  out  8  byte to transmit.
- dp_start  out  1  one-cycle start pulse to the datapath.
- dp_data  out  k  word presented to the datapath; held stable from dp_start until dp_done.
- dp_done  in  1  one-cycle completion pulse from the datapath.
- dp_result  in  k  decoded word; valid in the dp_done cycle.
- dp_err  in  1  uncorrectable-error flag; valid in the dp_done cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte index, gap counter and DP counter 0; dp_data 0.
- Word assembly: bytes arrive LSB-first; byte i fills dp_data[8i+7:8i]. Bits of the last byte at or above k are discarded.
- IDLE: on rx_valid, store byte 0, index=1, go to RX_COLLECT. If NB==1, go straight to LAUNCH.
- RX_COLLECT:
  - rx_valid stores the byte at the current index and clears the gap counter.
  - When index reaches NB-1 and that byte is stored, go to LAUNCH.
  - If the gap counter reaches GAP_CYC: drop the frame, clear the index, return to IDLE. Nothing is transmitted.
- LAUNCH: assert dp_start for exactly 1 cycle, clear the DP counter, go to WAIT_DP.
- WAIT_DP:
  - On dp_done: latch dp_result and dp_err, timeout=0, go to TX_SEND.
  - If the DP counter reaches DP_CYC: latch result=0, err=0, timeout=1, go to TX_SEND.
  - rx_valid in this state is ignored; the byte is lost and there is no queueing.
- TX_SEND:
  - Sends NB result bytes LSB-first, then the status byte {6'b0, timeout, err}.
  - A byte is issued only when tx_ready=1 and tx_valid was not asserted in the previous cycle. This enforces at least one idle cycle per byte so tx_ready can drop.
  - After the status byte is issued, return to IDLE.
  - rx_valid is ignored.
- Simultaneous events:
  - dp_done in the same cycle the DP counter hits DP_CYC: dp_done wins.
  - rx_valid in the same cycle the gap counter hits GAP_CYC: the byte is accepted.
- Reset mid-operation: returns to IDLE on the next clk edge. No pending tx_valid or dp_start is emitted afterwards.
- Latency: dp_start is asserted 2 cycles after the rx_valid of the last byte (store cycle, then LAUNCH). The first tx_valid comes no earlier than 1 cycle after dp_done.
- Counters are sized $clog2(max+1) and saturate; they never wrap.

Decomposition:
- Shared package/header: state encodings (IDLE, RX_COLLECT, LAUNCH, WAIT_DP, TX_SEND), status-byte bit positions, and the NB derivation function.
- One natural sub-module: sat_timeout_counter. It takes clear/enable inputs, a LIMIT parameter and a hit output, and is instantiated twice (gap and DP).

Test Plan:
- k=17. RX bytes 0x00,0x00,0x00; datapath model returns result=0, err=0 after 10 cycles. Required: one dp_start with dp_data=0, then TX 0x00,0x00,0x00,0x00.
- RX 0xA5,0x3C,0xFF. Required: dp_data=17'h13CA5 (bits above 16 dropped). Model echoes the word with err=1. Required TX: 0xA5,0x3C,0x01,0x01.
- RX 0x12,0x34, then silence for GAP_CYC cycles. Required: return to IDLE, no dp_start, no TX. A following 3-byte frame is then processed normally.
- Valid frame; model never asserts dp_done. Required: after DP_CYC cycles, TX 0x00,0x00,0x00,0x02.
- Hold tx_ready low for 50 cycles during TX_SEND. Required: no tx_valid while tx_ready is low, bytes resume in order, and tx_valid pulses are never back-to-back.
- Assert rst while in WAIT_DP. Required: busy=0 next cycle, no TX follows, and a subsequent frame processes correctly.
